// File: rtl/absorption_readout_ctrl_pkg.sv
// Shared types and default sizing for the absorption-array readout controller.
package absorption_readout_ctrl_pkg;

   localparam int unsigned ADDR_WIDTH_DEF   = 16;
   localparam int unsigned WORD_WIDTH_DEF   = 64;
   localparam int unsigned DRAIN_CYCLES_DEF = 37;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_ISSUE,
      ST_WAIT,
      ST_PRESENT,
      ST_FINISH
   } state_t;

endpackage

// File: rtl/abs_mem_port_mux.sv
// Selects who owns the absorption RAM ports: the photon pipeline or the readout sweep.
module abs_mem_port_mux #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned WORD_WIDTH = 64
) (
   input  logic                  passthrough,
   input  logic [ADDR_WIDTH-1:0] pipe_rdaddress,
   input  logic [ADDR_WIDTH-1:0] pipe_wraddress,
   input  logic [WORD_WIDTH-1:0] pipe_data,
   input  logic                  pipe_wren,
   output logic [WORD_WIDTH-1:0] pipe_q,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  clr_wren,
   input  logic [ADDR_WIDTH-1:0] clr_wraddress,
   output logic [ADDR_WIDTH-1:0] mem_rdaddress,
   output logic [ADDR_WIDTH-1:0] mem_wraddress,
   output logic [WORD_WIDTH-1:0] mem_data,
   output logic                  mem_wren,
   input  logic [WORD_WIDTH-1:0] mem_q
);

   assign pipe_q = mem_q;

   // Readout side only ever writes zeros (clear-on-read), never pipeline data.
   always_comb begin
      mem_rdaddress = rd_addr;
      mem_wraddress = clr_wraddress;
      mem_data      = '0;
      mem_wren      = clr_wren;
      if (passthrough) begin
         mem_rdaddress = pipe_rdaddress;
         mem_wraddress = pipe_wraddress;
         mem_data      = pipe_data;
         mem_wren      = pipe_wren;
      end
   end

endmodule

// File: rtl/absorption_readout_ctrl.sv
// Stops photon injection, drains the fluence pipeline, then streams the absorption array to the host.
// Optional: define ABS_CLEAR_ON_READ_EN to zero each word as it is handed to the host.
module absorption_readout_ctrl
   import absorption_readout_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int unsigned WORD_WIDTH   = WORD_WIDTH_DEF,
   parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   output logic                  inject_stop,
   output logic                  pipe_enable,
   input  logic [ADDR_WIDTH-1:0] pipe_rdaddress,
   input  logic [ADDR_WIDTH-1:0] pipe_wraddress,
   input  logic [WORD_WIDTH-1:0] pipe_data,
   input  logic                  pipe_wren,
   output logic [WORD_WIDTH-1:0] pipe_q,
   output logic [ADDR_WIDTH-1:0] mem_rdaddress,
   output logic [ADDR_WIDTH-1:0] mem_wraddress,
   output logic [WORD_WIDTH-1:0] mem_data,
   output logic                  mem_wren,
   input  logic [WORD_WIDTH-1:0] mem_q,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [WORD_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   state_t                state;
   state_t                state_next;
   logic [DRAIN_W-1:0]    drain_cnt;
   logic [DRAIN_W-1:0]    drain_next;
   logic [ADDR_WIDTH-1:0] addr_cnt;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic                  out_load;
   logic                  passthrough;
   logic                  handshake;
   logic                  clr_wren;

   assign passthrough = (state == ST_IDLE) || (state == ST_DRAIN);
   assign handshake   = (state == ST_PRESENT) && out_ready;

`ifdef ABS_CLEAR_ON_READ_EN
   assign clr_wren = handshake;
`else
   assign clr_wren = 1'b0;
`endif

   abs_mem_port_mux #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WORD_WIDTH (WORD_WIDTH)
   ) u_mux (
      .passthrough    (passthrough),
      .pipe_rdaddress (pipe_rdaddress),
      .pipe_wraddress (pipe_wraddress),
      .pipe_data      (pipe_data),
      .pipe_wren      (pipe_wren),
      .pipe_q         (pipe_q),
      .rd_addr        (addr_cnt),
      .clr_wren       (clr_wren),
      .clr_wraddress  (out_addr),
      .mem_rdaddress  (mem_rdaddress),
      .mem_wraddress  (mem_wraddress),
      .mem_data       (mem_data),
      .mem_wren       (mem_wren),
      .mem_q          (mem_q)
   );

   // State and counter registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         drain_cnt <= '0;
         addr_cnt  <= '0;
      end else begin
         state     <= state_next;
         drain_cnt <= drain_next;
         addr_cnt  <= addr_next;
      end
   end

   // Next-state logic; the last address ends the sweep instead of wrapping.
   always_comb begin
      state_next = state;
      drain_next = drain_cnt;
      addr_next  = addr_cnt;
      out_load   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_DRAIN;
               drain_next = DRAIN_W'(DRAIN_CYCLES - 1);
               addr_next  = '0;
            end
         end
         ST_DRAIN: begin
            if (drain_cnt == '0) state_next = ST_ISSUE;
            else                 drain_next = drain_cnt - DRAIN_W'(1);
         end
         ST_ISSUE: state_next = ST_WAIT;
         ST_WAIT: begin
            out_load   = 1'b1;
            state_next = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (out_ready) begin
               if (&addr_cnt) begin
                  state_next = ST_FINISH;
               end else begin
                  addr_next  = addr_cnt + ADDR_WIDTH'(1);
                  state_next = ST_ISSUE;
               end
            end
         end
         ST_FINISH: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         inject_stop <= 1'b0;
         pipe_enable <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_addr    <= '0;
      end else begin
         inject_stop <= (state_next != ST_IDLE);
         pipe_enable <= (state_next == ST_IDLE) || (state_next == ST_DRAIN);
         busy        <= (state_next != ST_IDLE);
         done        <= (state_next == ST_FINISH);
         out_valid   <= (state_next == ST_PRESENT);
         if (out_load) begin
            out_data <= mem_q;
            out_addr <= addr_cnt;
         end
      end
   end

endmodule

// File: doc/absorption_readout_ctrl.md
ABSORPTION_READOUT_CTRL -- requirements
Module: absorption_readout_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, absorption memory address width (NR*NZ = 2^16).
REQ-002 SHALL have parameter WORD_WIDTH, default 64, absorption memory word width.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 37, number of cycles needed to flush the fluence-update pipeline.
REQ-004 SHALL have ports; reset is synchronous, active-high, and the clock is named clock:
  clock  in  1  system clock
  reset  in  1  synchronous, active-high reset
  start  in  1  single-cycle readout request
  inject_stop  out  1  tells the photon source to stop injecting photons
  pipe_enable  out  1  enable for the photon pipeline
  pipe_rdaddress  in  ADDR_WIDTH  pipeline read address
  pipe_wraddress  in  ADDR_WIDTH  pipeline write address
  pipe_data  in  WORD_WIDTH  pipeline write data
  pipe_wren  in  1  pipeline write enable
  pipe_q  out  WORD_WIDTH  memory read data returned to the pipeline
  mem_rdaddress  out  ADDR_WIDTH  dual-port RAM read address
  mem_wraddress  out  ADDR_WIDTH  dual-port RAM write address
  mem_data  out  WORD_WIDTH  dual-port RAM write data
  mem_wren  out  1  dual-port RAM write enable
  mem_q  in  WORD_WIDTH  dual-port RAM read data, 1-cycle read latency
  out_addr  out  ADDR_WIDTH  address of the presented word
  out_data  out  WORD_WIDTH  presented absorption word
  out_valid  out  1  presented word is valid
  out_ready  in  1  host accepts the presented word
  busy  out  1  readout in progress
  done  out  1  one-cycle pulse at readout completion

Function
REQ-005 SHALL implement an FSM with states IDLE, DRAIN, ISSUE, WAIT, PRESENT and FINISH.
REQ-006 In IDLE, start=1 SHALL move the FSM to DRAIN, load the drain counter with DRAIN_CYCLES-1, and clear the address counter to 0.
REQ-007 In IDLE and DRAIN, mem_* SHALL pass pipe_* through combinationally and pipe_q SHALL equal mem_q.
REQ-008 In DRAIN, inject_stop SHALL be 1, pipe_enable SHALL remain 1, and the counter SHALL decrement each cycle; at 0 the FSM SHALL go to ISSUE.
REQ-009 In every state from ISSUE through FINISH, pipe_enable SHALL be 0 and inject_stop SHALL be 1; pipe_wren SHALL be ignored.
REQ-010 In ISSUE, mem_rdaddress SHALL equal the address counter, and the FSM SHALL go to WAIT on the next cycle.
REQ-011 In WAIT, mem_q SHALL be registered into out_data and the address counter into out_addr, and the FSM SHALL go to PRESENT.
REQ-012 In PRESENT:
  - out_valid SHALL be 1.
  - out_data and out_addr SHALL stay stable while out_ready=0.
REQ-013 On a PRESENT handshake (out_valid & out_ready), the FSM SHALL go to FINISH if the address counter is all ones; otherwise it SHALL increment the counter and go to ISSUE.
REQ-014 In FINISH, done SHALL be 1 for exactly one cycle, and the FSM SHALL then go to IDLE with inject_stop=0 and pipe_enable=1.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 start asserted outside IDLE SHALL be ignored.
REQ-017 Outside IDLE and DRAIN, mem_wren SHALL be 0 except as permitted by REQ-021.
REQ-018 Address counter wrap-around SHALL NOT occur; FINISH SHALL be taken instead.

Reset
REQ-019 On reset, the FSM SHALL enter IDLE and the outputs SHALL take these values:
  - inject_stop=0, pipe_enable=1
  - out_valid=0, out_data=0, out_addr=0
  - busy=0, done=0
  - address and drain counters=0
REQ-020 Reset asserted mid-readout SHALL abandon the sweep; no partial done pulse SHALL be produced.

Configuration
REQ-021 With ABS_CLEAR_ON_READ_EN defined, each PRESENT handshake SHALL drive, in that same cycle:
  - mem_wren=1
  - mem_wraddress=out_addr
  - mem_data=0
  This zeroes the array as it is read.
REQ-022 Without ABS_CLEAR_ON_READ_EN, mem_wren SHALL be 0 in every state from ISSUE through FINISH, and the memory contents SHALL be preserved.

Structure
REQ-023 A shared package SHALL hold:
  - the FSM state enumeration
  - ADDR_WIDTH, WORD_WIDTH and DRAIN_CYCLES defaults
REQ-024 The pipe/readout memory-port multiplexer SHALL be a sub-module named abs_mem_port_mux; all other logic SHALL be flat.

Verification
REQ-025 Drain timing: start in IDLE -> busy=1 next cycle; pipe_enable stays 1 for 37 cycles, then 0; the first mem_rdaddress=0 appears 1 cycle later.
REQ-026 Full sweep: RAM preloaded with word[a]=a*3 and out_ready tied high -> 65536 handshakes with out_data=out_addr*3 in ascending order; done pulses once; pipe_enable returns to 1.
REQ-027 Backpressure: out_ready=0 for 10 cycles at address 0x00FF -> out_data and out_addr stay constant; no address is skipped or repeated.
REQ-028 Clear-on-read: with ABS_CLEAR_ON_READ_EN, a full sweep followed by a second sweep -> all 65536 words read 0; without the macro, the second sweep matches the first.
REQ-029 Reset mid-sweep at address 0x1234 -> the next cycle shows IDLE, busy=0, out_valid=0, pipe_enable=1; no done pulse.
REQ-030 Passthrough: in IDLE, pipe_wren=1, pipe_wraddress=0x0102, pipe_data=5 -> mem_wren=1, mem_wraddress=0x0102, mem_data=5 in the same cycle; start during busy is ignored.
